// File: rtl/ro_pair_scheduler.sv
// Ring-oscillator PUF pair scheduler: selects two oscillators, lets them settle,
// counts synchronized rising edges of both mux outputs over a window and compares.
module ro_pair_scheduler #(
    parameter int WINDOW = 256,
    parameter int SETTLE = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       challenge,
    input  logic             mux_out_a,
    input  logic             mux_out_b,
    output logic [2:0]       sel_a,
    output logic [2:0]       sel_b,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic             response,
    output logic             tie,
    output logic             err,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_COMPARE
    } state_t;

    // One shared phase timer serves both SETTLE and COUNT; it only counts to LAST.
    localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t           state_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [2:0]       sel_a_reg;
    logic [2:0]       sel_b_reg;
    logic             ro_en_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             response_reg;
    logic             tie_reg;
    logic             err_reg;

    logic             challenge_ok;
    logic             accept;
    logic             counting;
    logic [1:0]       mux_in;
    logic [1:0]       edge_det;
    logic [CNT_W-1:0] cnt_all [2];

    assign challenge_ok = (challenge[2:0] != challenge[5:3]);
    assign accept       = (state_reg == ST_IDLE) && start && challenge_ok;
    assign counting     = (state_reg == ST_COUNT);
    assign mux_in       = {mux_out_b, mux_out_a};

    // Channel 0 is mux A, channel 1 is mux B.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_ch
            logic [2:0]       sync_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= 3'b000;
                end else begin
                    sync_reg <= {sync_reg[1:0], mux_in[gi]};
                end
            end

            // Bit 1 is the second synchronizer stage, bit 2 its history copy.
            assign edge_det[gi] = sync_reg[1] & ~sync_reg[2];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (accept) begin
                    cnt_reg <= '0;
                end else if (counting && edge_det[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign cnt_all[gi] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            timer_reg    <= '0;
            sel_a_reg    <= 3'd0;
            sel_b_reg    <= 3'd0;
            ro_en_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            response_reg <= 1'b0;
            tie_reg      <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (challenge_ok) begin
                            sel_a_reg <= challenge[2:0];
                            sel_b_reg <= challenge[5:3];
                            timer_reg <= '0;
                            ro_en_reg <= 1'b1;
                            busy_reg  <= 1'b1;
                            err_reg   <= 1'b0;
                            state_reg <= ST_SETTLE;
                        end else begin
                            // Same oscillator on both sides: report at once, no measurement.
                            done_reg     <= 1'b1;
                            err_reg      <= 1'b1;
                            response_reg <= 1'b0;
                            tie_reg      <= 1'b0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (timer_reg == SETTLE_LAST) begin
                        timer_reg <= '0;
                        state_reg <= ST_COUNT;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (timer_reg == WINDOW_LAST) begin
                        timer_reg <= '0;
                        state_reg <= ST_COMPARE;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                ST_COMPARE: begin
                    response_reg <= (cnt_all[0] > cnt_all[1]);
                    tie_reg      <= (cnt_all[0] == cnt_all[1]);
                    err_reg      <= 1'b0;
                    ro_en_reg    <= 1'b0;
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b1;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel_a    = sel_a_reg;
    assign sel_b    = sel_b_reg;
    assign ro_en    = ro_en_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign response = response_reg;
    assign tie      = tie_reg;
    assign err      = err_reg;
    assign cnt_a    = cnt_all[0];
    assign cnt_b    = cnt_all[1];

endmodule

// File: tb/tb_ro_pair_scheduler.sv
// Directed bench for ro_pair_scheduler: one main instance (WINDOW=16, SETTLE=2)
// and a narrow-counter instance (CNT_W=2, WINDOW=32) for saturation.
module tb_ro_pair_scheduler;

    localparam int WIN   = 16;
    localparam int SET   = 2;
    localparam int WIN_S = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start_s = 1'b0;
    logic [5:0] challenge = 6'd0;
    logic       mux_a = 1'b0;
    logic       mux_b = 1'b0;

    logic [2:0]  sel_a, sel_b;
    logic        ro_en, busy, done, response, tie, err;
    logic [15:0] cnt_a, cnt_b;

    logic [2:0]  sel_a_s, sel_b_s;
    logic        ro_en_s, busy_s, done_s, response_s, tie_s, err_s;
    logic [1:0]  cnt_a_s, cnt_b_s;

    int errors = 0;
    int checks = 0;
    int a_period = 0;
    int b_period = 0;
    bit b_same = 1'b0;
    int ph = 0;

    ro_pair_scheduler #(.WINDOW(WIN), .SETTLE(SET), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .mux_out_a(mux_a), .mux_out_b(mux_b),
        .sel_a(sel_a), .sel_b(sel_b), .ro_en(ro_en), .busy(busy), .done(done),
        .response(response), .tie(tie), .err(err), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    ro_pair_scheduler #(.WINDOW(WIN_S), .SETTLE(SET), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .challenge(challenge),
        .mux_out_a(mux_a), .mux_out_b(mux_b),
        .sel_a(sel_a_s), .sel_b(sel_b_s), .ro_en(ro_en_s), .busy(busy_s), .done(done_s),
        .response(response_s), .tie(tie_s), .err(err_s), .cnt_a(cnt_a_s), .cnt_b(cnt_b_s)
    );

    always #5 clk = ~clk;

    // Oscillator stand-ins: square waves stepped on the falling clock edge.
    always @(negedge clk) begin
        ph = ph + 1;
        mux_a = (a_period != 0) && ((ph % a_period) < (a_period / 2));
        if (b_same) mux_b = mux_a;
        else        mux_b = (b_period != 0) && ((ph % b_period) < (b_period / 2));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < limit);
    endtask

    task automatic wait_done_s(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done_s && n < limit);
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({sel_a, sel_b, ro_en, busy, done, response, tie, err} !== 12'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 0", {sel_a, sel_b, ro_en, busy, done, response, tie, err});
        end
        checks++;
        if ({cnt_a, cnt_b} !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt: got a=%0d b=%0d, want 0 0", cnt_a, cnt_b);
        end
        checks++;
        if ({sel_a_s, sel_b_s, ro_en_s, busy_s, done_s, response_s, tie_s, err_s, cnt_a_s, cnt_b_s} !== 16'd0) begin
            errors++;
            $display("FAIL reset_sat: got %b, want 0", {sel_a_s, sel_b_s, ro_en_s, busy_s, done_s, response_s, tie_s, err_s, cnt_a_s, cnt_b_s});
        end
        rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_reset_mid();
        int nd;
        int nen;
        a_period = 4; b_period = 8; b_same = 1'b0;
        @(negedge clk);
        challenge = 6'b010_001;
        start = 1'b1;
        tick();
        start = 1'b0;
        challenge = 6'b111_111;
        checks++;
        if (sel_a !== 3'd1 || sel_b !== 3'd2 || busy !== 1'b1 || ro_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_accept: got sel_a=%0d sel_b=%0d busy=%b ro_en=%b, want 1 2 1 1", sel_a, sel_b, busy, ro_en);
        end
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sel_a, sel_b, ro_en, busy, done, response, tie, err} !== 12'd0 || {cnt_a, cnt_b} !== 32'd0) begin
            errors++;
            $display("FAIL mid_async_reset: got ctrl=%b a=%0d b=%0d, want all 0",
                     {sel_a, sel_b, ro_en, busy, done, response, tie, err}, cnt_a, cnt_b);
        end
        tick();
        rst_n = 1'b1;
        nd = 0; nen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) nd++;
            if (ro_en) nen++;
        end
        checks++;
        if (nd !== 0 || nen !== 0) begin
            errors++;
            $display("FAIL mid_after_reset: got done_pulses=%0d ro_en_cycles=%0d, want 0 0", nd, nen);
        end
        $display("reset_mid: done_pulses=%0d ro_en_cycles=%0d", nd, nen);
    endtask

    task automatic test_a_faster();
        int n;
        int elapsed;
        a_period = 4; b_period = 8; b_same = 1'b0;
        @(negedge clk);
        challenge = 6'b011_000;
        start = 1'b1;
        tick();
        start = 1'b0;
        challenge = 6'b000_000;
        checks++;
        if (sel_a !== 3'd0 || sel_b !== 3'd3 || busy !== 1'b1 || ro_en !== 1'b1) begin
            errors++;
            $display("FAIL fast_accept: got sel_a=%0d sel_b=%0d busy=%b ro_en=%b, want 0 3 1 1", sel_a, sel_b, busy, ro_en);
        end
        repeat (3) tick();
        start = 1'b1;
        challenge = 6'b001_010;
        tick();
        start = 1'b0;
        checks++;
        if (sel_a !== 3'd0 || sel_b !== 3'd3) begin
            errors++;
            $display("FAIL busy_start_ignored: got sel_a=%0d sel_b=%0d, want 0 3", sel_a, sel_b);
        end
        wait_done(40, n);
        elapsed = 4 + n;
        checks++;
        if (elapsed !== SET + WIN + 1) begin
            errors++;
            $display("FAIL fast_latency: got %0d, want %0d", elapsed, SET + WIN + 1);
        end
        checks++;
        if (cnt_a < 3 || cnt_a > 5 || cnt_b < 1 || cnt_b > 3) begin
            errors++;
            $display("FAIL fast_counts: got a=%0d b=%0d, want a 3..5 b 1..3", cnt_a, cnt_b);
        end
        checks++;
        if (response !== 1'b1 || tie !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || ro_en !== 1'b0) begin
            errors++;
            $display("FAIL fast_result: got resp=%b tie=%b err=%b busy=%b ro_en=%b, want 1 0 0 0 0", response, tie, err, busy, ro_en);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: got done=%b, want 0", done);
        end
        repeat (3) tick();
        checks++;
        if (response !== 1'b1) begin
            errors++;
            $display("FAIL response_hold: got %b, want 1", response);
        end
        $display("a_faster: latency=%0d cnt_a=%0d cnt_b=%0d resp=%b tie=%b", elapsed, cnt_a, cnt_b, response, tie);
    endtask

    task automatic test_equal();
        int n;
        a_period = 4; b_period = 0; b_same = 1'b1;
        @(negedge clk);
        challenge = 6'b000_111;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (sel_a !== 3'd7 || sel_b !== 3'd0 || response !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL equal_accept: got sel_a=%0d sel_b=%0d resp=%b busy=%b, want 7 0 1 1", sel_a, sel_b, response, busy);
        end
        wait_done(40, n);
        checks++;
        if (n !== SET + WIN + 1) begin
            errors++;
            $display("FAIL equal_latency: got %0d, want %0d", n, SET + WIN + 1);
        end
        checks++;
        if (cnt_a !== cnt_b || cnt_a < 3 || cnt_a > 5) begin
            errors++;
            $display("FAIL equal_counts: got a=%0d b=%0d, want equal in 3..5", cnt_a, cnt_b);
        end
        checks++;
        if (tie !== 1'b1 || response !== 1'b0) begin
            errors++;
            $display("FAIL equal_result: got tie=%b resp=%b, want 1 0", tie, response);
        end
        $display("equal: cnt_a=%0d cnt_b=%0d tie=%b resp=%b", cnt_a, cnt_b, tie, response);
    endtask

    task automatic test_invalid();
        @(negedge clk);
        challenge = 6'b101_101;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || response !== 1'b0 || tie !== 1'b0) begin
            errors++;
            $display("FAIL invalid_report: got done=%b err=%b resp=%b tie=%b, want 1 1 0 0", done, err, response, tie);
        end
        checks++;
        if (busy !== 1'b0 || ro_en !== 1'b0 || sel_a !== 3'd7 || sel_b !== 3'd0) begin
            errors++;
            $display("FAIL invalid_hold: got busy=%b ro_en=%b sel_a=%0d sel_b=%0d, want 0 0 7 0", busy, ro_en, sel_a, sel_b);
        end
        checks++;
        if (cnt_a !== cnt_b || cnt_a < 3 || cnt_a > 5) begin
            errors++;
            $display("FAIL invalid_cnt_keep: got a=%0d b=%0d, want unchanged equal 3..5", cnt_a, cnt_b);
        end
        tick();
        checks++;
        if (done !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL invalid_after: got done=%b err=%b busy=%b, want 0 1 0", done, err, busy);
        end
        $display("invalid: err=%b busy=%b sel_a=%0d sel_b=%0d", err, busy, sel_a, sel_b);
    endtask

    task automatic test_back_to_back();
        int nd;
        int done_at [4];
        a_period = 4; b_period = 8; b_same = 1'b0;
        nd = 0;
        for (int k = 0; k < 4; k++) done_at[k] = 0;
        @(negedge clk);
        challenge = 6'b011_000;
        start = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (c == 0) begin
                checks++;
                if (err !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_err_clear: got err=%b busy=%b, want 0 1", err, busy);
                end
            end
            if (done) begin
                if (nd < 4) done_at[nd] = c;
                nd++;
                if (nd == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (nd !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses, want 3", nd);
        end
        checks++;
        if (done_at[0] !== SET + WIN + 1) begin
            errors++;
            $display("FAIL b2b_first: got cycle %0d, want %0d", done_at[0], SET + WIN + 1);
        end
        checks++;
        if (done_at[1] - done_at[0] !== 20 || done_at[2] - done_at[1] !== 20) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d %0d, want 20 20", done_at[1] - done_at[0], done_at[2] - done_at[1]);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b, want 0", busy);
        end
        $display("back_to_back: pulses=%0d at %0d %0d %0d", nd, done_at[0], done_at[1], done_at[2]);
    endtask

    task automatic test_saturation();
        int n;
        a_period = 4; b_period = 0; b_same = 1'b0;
        @(negedge clk);
        challenge = 6'b011_000;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        wait_done_s(60, n);
        checks++;
        if (n !== SET + WIN_S + 1) begin
            errors++;
            $display("FAIL sat_latency: got %0d, want %0d", n, SET + WIN_S + 1);
        end
        checks++;
        if (cnt_a_s !== 2'd3 || cnt_b_s !== 2'd0) begin
            errors++;
            $display("FAIL sat_counts: got a=%0d b=%0d, want 3 0", cnt_a_s, cnt_b_s);
        end
        checks++;
        if (response_s !== 1'b1 || tie_s !== 1'b0) begin
            errors++;
            $display("FAIL sat_result: got resp=%b tie=%b, want 1 0", response_s, tie_s);
        end
        $display("saturation: cnt_a=%0d cnt_b=%0d resp=%b", cnt_a_s, cnt_b_s, response_s);
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_a_faster();
        test_equal();
        test_invalid();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ro_pair_scheduler.md
# ro_pair_scheduler

Sequencing controller for the ring-oscillator PUF datapath. It takes a 6-bit challenge and drives the select lines of two 8:1 `Multiplexer` instances (A and B) that pick one oscillator each. It enables the oscillators, lets them settle, and counts rising edges of each mux output over a fixed window. It then compares the two counts and returns one response bit with a done pulse.

## Interface
- `WINDOW`, default 256: count-window length, in clk cycles (≥2).
- `SETTLE`, default 4: cycles after the select change and oscillator enable, before counting starts (≥1).
- `CNT_W`, default 16: width of each edge counter.

- `clk` input 1: single system clock, rising-edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: request a measurement; sampled only in IDLE.
- `challenge` input 6: `[2:0]` selects the mux A oscillator, `[5:3]` selects the mux B oscillator.
- `mux_out_a` input 1: mux A output; asynchronous to clk.
- `mux_out_b` input 1: mux B output; asynchronous to clk.
- `sel_a` output 3: registered select for mux A.
- `sel_b` output 3: registered select for mux B.
- `ro_en` output 1: oscillator enable.
- `busy` output 1: a measurement is in progress.
- `done` output 1: one-cycle completion pulse.
- `response` output 1: result bit, 1 when cnt_a > cnt_b.
- `tie` output 1: cnt_a == cnt_b.
- `err` output 1: invalid challenge (sel_a == sel_b).
- `cnt_a` output CNT_W: final count for mux A, held until the next accepted start.
- `cnt_b` output CNT_W: final count for mux B, held until the next accepted start.

## Operation
- FSM states: IDLE, SETTLE, COUNT, COMPARE.
- IDLE, start=1, challenge[2:0] ≠ challenge[5:3]:
  - Load sel_a and sel_b.
  - Clear both counters and the settle/window counter.
  - Set ro_en=1 and busy=1.
  - Go to SETTLE.
- IDLE, start=1, challenge[2:0] == challenge[5:3]:
  - Stay in IDLE. sel_a, sel_b, ro_en and busy do not change.
  - Next cycle: done=1, err=1, response=0, tie=0.
  - cnt_a and cnt_b keep their previous values.
- SETTLE: hold for SETTLE cycles. Edges seen in this state are not counted. Then go to COUNT.
- COUNT: hold for WINDOW cycles.
  - Each detected rising edge of a mux output increments that mux's counter.
  - Counters saturate at 2^CNT_W−1; no wrap.
  - Then go to COMPARE.
- COMPARE, one cycle:
  - Register response = (cnt_a > cnt_b) and tie = (cnt_a == cnt_b).
  - Clear err and ro_en.
  - Go to IDLE with done=1 in the following cycle.
- Edge detection per input:
  - 2-flop synchronizer, then a history flop.
  - edge = s2 & ~s3.
  - Oscillators must be divided so that each mux output stays below clk/4.
- start while busy is ignored. No queuing.
- challenge is sampled only on the accepting edge. Later changes have no effect.
- response, tie and err hold until the next accepted start.
  - Accepting a valid start clears err.
  - response and tie keep their old values until COMPARE.

## Timing
- Reset (rst_n=0, any time, including mid-measurement) forces:
  - state=IDLE.
  - sel_a=sel_b=0, ro_en=0, busy=0, done=0, response=0, tie=0, err=0.
  - cnt_a=cnt_b=0, synchronizer flops=0.
- Release of rst_n is synchronous to clk. The first start can be accepted on the first clk edge after release.
- Start accepted at edge T0:
  - sel_a, sel_b, ro_en and busy take new values after T0.
  - SETTLE covers edges T1..T(SETTLE).
  - COUNT covers the next WINDOW edges.
  - COMPARE takes one edge.
  - done=1 and busy=0 in the cycle after COMPARE, i.e. SETTLE+WINDOW+1 cycles after T0. done lasts exactly one cycle.
- A start asserted in the done cycle is accepted (the FSM is in IDLE).
- Synchronizer latency is 2 cycles. An edge arriving in the last 2 COUNT cycles may be missed. Benches allow ±1 on each count.
- Invalid challenge: done and err are high 1 cycle after the accepting edge. busy never rises.

## Test plan
1. Reset mid-measurement: start with challenge=6'b010_001, assert rst_n=0 during COUNT -> all outputs 0 at once; no done afterwards; ro_en=0.
2. A faster than B, with bench parameters WINDOW=16, SETTLE=2, challenge=6'b011_000:
   - Stimulus: mux_out_a period 4 clk, mux_out_b period 8 clk.
   - Required: sel_a=0, sel_b=3; done at T0+19; cnt_a∈{3,4,5}, cnt_b∈{1,2,3}; response=1, tie=0.
3. Equal counts: mux_out_a and mux_out_b driven by the same period-4 wave -> cnt_a==cnt_b, tie=1, response=0.
4. Invalid challenge 6'b101_101 -> done and err=1 at T0+1; busy stays 0; sel_a and sel_b unchanged.
5. start held high continuously for 3 measurements -> back-to-back acceptance in each done cycle; exactly 3 done pulses, 20 cycles apart (bench parameters).
6. Saturation: CNT_W=2, mux_out_a period 4, WINDOW=32 -> cnt_a=3 with no wrap to 0.
